// File: rtl/pll_reconfig_slave_if.sv
// Management bus between the reconfig sequencer (master) and the PLL reconfig slave.
// The slave stalls the master with mgmt_waitrequest; a transfer completes in a cycle where it is low.
interface pll_reconfig_slave_if;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_read;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;

    modport master (
        output mgmt_address, mgmt_write, mgmt_writedata, mgmt_read,
        input  mgmt_readdata, mgmt_waitrequest
    );

    modport slave (
        input  mgmt_address, mgmt_write, mgmt_writedata, mgmt_read,
        output mgmt_readdata, mgmt_waitrequest
    );
endinterface

// File: rtl/pll_reconfig_slave.sv
// PLL reconfig responder: shadow register writes, START publishes M/N/C/K BUSY_CYCLES+1 cycles later.
// Backpressure: waitrequest held in every non-idle state in waitrequest mode, never in polling mode.
module pll_reconfig_slave #(
    parameter int NUM_C        = 5,
    parameter int BUSY_CYCLES  = 16,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                   mgmt_clk,
    input  logic                   mgmt_reset,
    pll_reconfig_slave_if.slave    mgmt,
    input  logic                   pll_locked_in,
    output logic                   cfg_apply,
    output logic                   cfg_busy,
    output logic [17:0]            cfg_m,
    output logic [17:0]            cfg_n,
    output logic [31:0]            cfg_k,
    output logic [NUM_C*18-1:0]    cfg_c
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_APPLY, S_LOCK_WAIT} state_e;

    localparam logic [5:0] A_MODE   = 6'd0;
    localparam logic [5:0] A_STATUS = 6'd1;
    localparam logic [5:0] A_START  = 6'd2;
    localparam logic [5:0] A_N      = 6'd3;
    localparam logic [5:0] A_M      = 6'd4;
    localparam logic [5:0] A_C      = 6'd5;
    localparam logic [5:0] A_K      = 6'd7;

    state_e               state_q, state_d;
    logic [31:0]          cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic                 lock_to_q, lock_to_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [17:0]          sh_n_q, sh_n_d, sh_m_q, sh_m_d;
    logic [31:0]          sh_k_q, sh_k_d;
    logic [NUM_C*18-1:0]  sh_c_q, sh_c_d;
    logic [17:0]          pend_n_q, pend_n_d, pend_m_q, pend_m_d;
    logic [31:0]          pend_k_q, pend_k_d;
    logic [NUM_C*18-1:0]  pend_c_q, pend_c_d;
    logic [17:0]          cfg_n_q, cfg_n_d, cfg_m_q, cfg_m_d;
    logic [31:0]          cfg_k_q, cfg_k_d;
    logic [NUM_C*18-1:0]  cfg_c_q, cfg_c_d;
    logic                 cfg_apply_q, cfg_apply_d;

    logic                 busy;
    logic                 waitreq;
    logic                 wr_acc;
    logic                 rd_acc;

    assign busy    = (state_q != S_IDLE);
    assign waitreq = busy && !mode_q;
    assign wr_acc  = mgmt.mgmt_write && !waitreq;
    assign rd_acc  = mgmt.mgmt_read && !mgmt.mgmt_write && !waitreq;

    assign mgmt.mgmt_waitrequest = waitreq;
    assign mgmt.mgmt_readdata    = rdata_q;
    assign cfg_busy  = busy;
    assign cfg_apply = cfg_apply_q;
    assign cfg_m     = cfg_m_q;
    assign cfg_n     = cfg_n_q;
    assign cfg_k     = cfg_k_q;
    assign cfg_c     = cfg_c_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        lock_to_d   = lock_to_q;
        rdata_d     = rdata_q;
        sh_n_d      = sh_n_q;
        sh_m_d      = sh_m_q;
        sh_k_d      = sh_k_q;
        sh_c_d      = sh_c_q;
        pend_n_d    = pend_n_q;
        pend_m_d    = pend_m_q;
        pend_k_d    = pend_k_q;
        pend_c_d    = pend_c_q;
        cfg_n_d     = cfg_n_q;
        cfg_m_d     = cfg_m_q;
        cfg_k_d     = cfg_k_q;
        cfg_c_d     = cfg_c_q;
        cfg_apply_d = 1'b0;

        if (wr_acc) begin
            case (mgmt.mgmt_address)
                A_MODE: mode_d = mgmt.mgmt_writedata[0];
                A_N:    sh_n_d = mgmt.mgmt_writedata[17:0];
                A_M:    sh_m_d = mgmt.mgmt_writedata[17:0];
                A_K:    sh_k_d = mgmt.mgmt_writedata;
                A_C: begin
                    // Indices at or above NUM_C match no slot and fall through untouched.
                    for (int i = 0; i < NUM_C; i++) begin
                        if (mgmt.mgmt_writedata[22:18] == 5'(i)) begin
                            sh_c_d[i*18 +: 18] = mgmt.mgmt_writedata[17:0];
                        end
                    end
                end
                default: ;
            endcase
        end

        if (rd_acc) begin
            case (mgmt.mgmt_address)
                A_MODE:   rdata_d = {31'd0, mode_q};
                A_STATUS: rdata_d = {30'd0, lock_to_q, busy};
                A_N:      rdata_d = {14'd0, sh_n_q};
                A_M:      rdata_d = {14'd0, sh_m_q};
                A_K:      rdata_d = sh_k_q;
                default:  rdata_d = 32'd0;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                // Snapshot at START so writes made while busy wait for the next apply.
                if (wr_acc && mgmt.mgmt_address == A_START) begin
                    state_d   = S_BUSY;
                    cnt_d     = 32'(BUSY_CYCLES - 1);
                    lock_to_d = 1'b0;
                    pend_n_d  = sh_n_q;
                    pend_m_d  = sh_m_q;
                    pend_k_d  = sh_k_q;
                    pend_c_d  = sh_c_q;
                end
            end
            S_BUSY: begin
                if (cnt_q == 32'd0) begin
                    state_d = S_APPLY;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_APPLY: begin
                cfg_n_d     = pend_n_q;
                cfg_m_d     = pend_m_q;
                cfg_k_d     = pend_k_q;
                cfg_c_d     = pend_c_q;
                cfg_apply_d = 1'b1;
                state_d     = S_LOCK_WAIT;
                cnt_d       = 32'(LOCK_TIMEOUT - 1);
            end
            S_LOCK_WAIT: begin
                if (pll_locked_in) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 32'd0) begin
                    lock_to_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge mgmt_clk or posedge mgmt_reset) begin
        if (mgmt_reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            lock_to_q   <= 1'b0;
            rdata_q     <= '0;
            sh_n_q      <= '0;
            sh_m_q      <= '0;
            sh_k_q      <= '0;
            sh_c_q      <= '0;
            pend_n_q    <= '0;
            pend_m_q    <= '0;
            pend_k_q    <= '0;
            pend_c_q    <= '0;
            cfg_n_q     <= '0;
            cfg_m_q     <= '0;
            cfg_k_q     <= '0;
            cfg_c_q     <= '0;
            cfg_apply_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            lock_to_q   <= lock_to_d;
            rdata_q     <= rdata_d;
            sh_n_q      <= sh_n_d;
            sh_m_q      <= sh_m_d;
            sh_k_q      <= sh_k_d;
            sh_c_q      <= sh_c_d;
            pend_n_q    <= pend_n_d;
            pend_m_q    <= pend_m_d;
            pend_k_q    <= pend_k_d;
            pend_c_q    <= pend_c_d;
            cfg_n_q     <= cfg_n_d;
            cfg_m_q     <= cfg_m_d;
            cfg_k_q     <= cfg_k_d;
            cfg_c_q     <= cfg_c_d;
            cfg_apply_q <= cfg_apply_d;
        end
    end
endmodule
